sub_32bit_pipe: RTL



---
 rtl/sub_pkg.sv | 38 +++
 rtl/cla16_unit.sv | 34 +++
 rtl/sub_32bit_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared widths, types and carry-lookahead helpers for the pipelined 32-bit subtractor.
package sub_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [HALF_W-1:0] half_t;

  // Everything stage 2 needs to finish the upper half and the flags.
  typedef struct packed {
    half_t s1_lo;
    logic  s1_c16;
    half_t s1_ahi;
    half_t s1_nbhi;
    logic  s1_asign;
    logic  s1_bsign;
  } stage1_t;

  // Carries into bits 0..3 of a 4-bit group, all expanded from cin.
  function automatic logic [3:0] cla4_carry_in(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Group generate of a 4-bit block: a carry leaves the group regardless of cin.
  function automatic logic cla4_group_gen(input logic [3:0] g,
                                          input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla16_unit.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit generate/propagate
// groups resolved by a second-level lookahead over the group signals.
module cla16_unit
  import sub_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] s,
  output logic              cout
);

  logic [HALF_W-1:0] g;
  logic [HALF_W-1:0] p;
  logic [HALF_W-1:0] c;
  logic [3:0]        grp_g;
  logic [3:0]        grp_p;
  logic [3:0]        grp_c;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign grp_g[k]      = cla4_group_gen(g[4*k +: 4], p[4*k +: 4]);
    assign grp_p[k]      = &p[4*k +: 4];
    assign c[4*k +: 4]   = cla4_carry_in(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
  end

  // Second level reuses the same lookahead equations on the group signals.
  assign grp_c = cla4_carry_in(grp_g, grp_p, cin);
  assign cout  = cla4_group_gen(grp_g, grp_p) | ((&grp_p) & cin);
  assign s     = p ^ c;

endmodule

// File: rtl/sub_32bit_pipe.sv
// Two-stage pipelined 32-bit subtractor D = A + ~B + 1 with borrow and signed
// overflow; low half in stage 1, high half in stage 2, valid/ready on both sides.
module sub_32bit_pipe
  import sub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] D,
  output logic              BORROW,
  output logic              OVF
);

  stage1_t s1_q, s1_d;
  logic    s1_valid_q, s1_valid_d;
  word_t   d_q, d_d;
  logic    borrow_q, borrow_d;
  logic    ovf_q, ovf_d;
  logic    out_valid_q, out_valid_d;

  half_t   nb_lo;
  half_t   lo_sum;
  logic    lo_cout;
  half_t   hi_sum;
  logic    hi_cout;
  logic    accept;
  logic    advance;

  assign nb_lo = ~B[HALF_W-1:0];

  // Forced carry-in of 1 completes the two's-complement negation of B.
  cla16_unit u_cla_lo (
    .a    (A[HALF_W-1:0]),
    .b    (nb_lo),
    .cin  (1'b1),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  cla16_unit u_cla_hi (
    .a    (s1_q.s1_ahi),
    .b    (s1_q.s1_nbhi),
    .cin  (s1_q.s1_c16),
    .s    (hi_sum),
    .cout (hi_cout)
  );

  // in_ready depends on out_ready only, never on in_valid.
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && (!out_valid_q || out_ready);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    d_d         = d_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      s1_d.s1_lo    = lo_sum;
      s1_d.s1_c16   = lo_cout;
      s1_d.s1_ahi   = A[WORD_W-1:HALF_W];
      s1_d.s1_nbhi  = ~B[WORD_W-1:HALF_W];
      s1_d.s1_asign = A[WORD_W-1];
      s1_d.s1_bsign = B[WORD_W-1];
      s1_valid_d    = 1'b1;
    end else if (advance) begin
      s1_valid_d    = 1'b0;
    end

    if (advance) begin
      d_d         = {hi_sum, s1_q.s1_lo};
      borrow_d    = ~hi_cout;
      ovf_d       = (s1_q.s1_asign != s1_q.s1_bsign) && (hi_sum[HALF_W-1] != s1_q.s1_asign);
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so D/BORROW/OVF read a defined 0 after reset.
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      d_q         <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      d_q         <= d_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign BORROW    = borrow_q;
  assign OVF       = ovf_q;

endmodule
